dtcore32_mem_arbiter: RTL
=========================

DTCORE32_MEM_ARBITER -- requirements
Module: dtcore32_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning max consecutive DMEM grants while IMEM waits.
REQ-002 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port imem_req_i  input  1  fetch request.
REQ-005 SHALL have port imem_addr_i  input  32  fetch byte address.
REQ-006 SHALL have port imem_gnt_o  output  1  fetch accepted this cycle.
REQ-007 SHALL have port imem_rvalid_o  output  1  fetch data valid.
REQ-008 SHALL have port imem_rdata_o  output  32  fetch data.
REQ-009 SHALL have port dmem_req_i  input  1  load/store request.
REQ-010 SHALL have port dmem_we_i  input  1  1 = store.
REQ-011 SHALL have port dmem_addr_i  input  32  data byte address.
REQ-012 SHALL have port dmem_wdata_i  input  32  store data.
REQ-013 SHALL have port dmem_be_i  input  4  store byte enables.
REQ-014 SHALL have port dmem_gnt_o  output  1  data request accepted this cycle.
REQ-015 SHALL have port dmem_rvalid_o  output  1  load data valid / store acknowledged.
REQ-016 SHALL have port dmem_rdata_o  output  32  load data.
REQ-017 SHALL have port mem_en_o  output  1  unified memory access strobe.
REQ-018 SHALL have ports mem_addr_o output 32, mem_wdata_o output 32, mem_we_o output 4 (byte write enables).
REQ-019 SHALL have port mem_rdata_i  input  32  memory read data, valid exactly one cycle after a read strobe.

Function
REQ-020 SHALL issue at most one grant per cycle; grant and mem_en_o are combinational from same-cycle requests.
REQ-021 SHALL grant DMEM when only DMEM requests, IMEM when only IMEM requests.
REQ-022 SHALL, when both request, grant DMEM unless starve count == STARVE_LIMIT, then grant IMEM.
REQ-023 Starve count (width clog2(STARVE_LIMIT+1)) SHALL increment on each DMEM grant with imem_req_i high, saturate at STARVE_LIMIT, clear on IMEM grant or imem_req_i low.
REQ-024 On grant, mem_addr_o SHALL equal winner's address; mem_we_o = dmem_be_i if DMEM store granted, else 0; mem_wdata_o = dmem_wdata_i.
REQ-025 With no grant, mem_en_o and mem_we_o SHALL be 0; address/wdata don't-care.
REQ-026 Owner FSM states IDLE, IMEM_PEND, DMEM_PEND; next state each cycle = IMEM_PEND on IMEM grant, DMEM_PEND on DMEM grant, else IDLE (back-to-back grants fully pipelined, one per cycle).
REQ-027 In IMEM_PEND, imem_rvalid_o = 1 and imem_rdata_o = mem_rdata_i; in DMEM_PEND, dmem_rvalid_o = 1, dmem_rdata_o = mem_rdata_i for loads, 0 for stores (stored flag).
REQ-028 Non-owner rvalid SHALL be 0 and its rdata 0.
REQ-029 Requesters hold req/address stable until gnt; arbiter SHALL not buffer ungranted requests.
REQ-030 Latency: grant cycle N, rvalid cycle N+1, for both ports.

Reset
REQ-031 While rst_i high, all gnt, rvalid, mem_en_o, mem_we_o SHALL be 0 and rdata outputs 0, asynchronously.
REQ-032 Reset SHALL set FSM to IDLE, starve count 0, store flag 0.
REQ-033 A request granted the cycle before reset asserts SHALL produce no rvalid after reset releases.

Structure
REQ-034 Owner-state enum and default STARVE_LIMIT SHALL live in shared package dtcore32_pkg.
REQ-035 No sub-module; single flat module, one always_ff for state/counter, combinational arbitration.

Verification
REQ-036 IMEM-only: imem_req_i=1, addr 0x100, mem_rdata_i=0x00000013 next cycle -> gnt same cycle, imem_rvalid_o=1, rdata 0x00000013 at N+1.
REQ-037 Contention: both request continuously, STARVE_LIMIT=4 -> grants D,D,D,D,I,D,D,D,D,I...
REQ-038 Store: dmem_we_i=1, be 0b0011, addr 0x2000, wdata 0xDEADBEEF -> mem_we_o=0b0011, mem_addr_o 0x2000; dmem_rvalid_o=1, rdata 0 at N+1.
REQ-039 Back-to-back: IMEM grant cycle N, DMEM load cycle N+1 -> imem_rvalid at N+1, dmem_rvalid at N+2, no overlap.
REQ-040 Reset mid-op: grant IMEM cycle N, assert rst_i before edge N+1 -> imem_rvalid_o stays 0; post-reset starve count 0.

Source files
------------

// File: rtl/dtcore32_pkg.sv
// Shared dtcore32 types: memory-arbiter owner states and the default starvation bound.
package dtcore32_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IMEM_PEND = 2'd1,
    DMEM_PEND = 2'd2
  } owner_e;

endpackage

// File: rtl/dtcore32_mem_arbiter.sv
// Arbitrates fetch and load/store traffic onto one single-ported memory.
// Grants are combinational and fixed-latency; read data returns one cycle later.
module dtcore32_mem_arbiter
  import dtcore32_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_req_i,
  input  logic [31:0] imem_addr_i,
  output logic        imem_gnt_o,
  output logic        imem_rvalid_o,
  output logic [31:0] imem_rdata_o,
  input  logic        dmem_req_i,
  input  logic        dmem_we_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_be_i,
  output logic        dmem_gnt_o,
  output logic        dmem_rvalid_o,
  output logic [31:0] dmem_rdata_o,
  output logic        mem_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_we_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  owner_e           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             store_q, store_d;
  logic             imem_win, dmem_win;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == LIMIT_C) ? v : v + 1'b1;
  endfunction

  // DMEM has priority until IMEM has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    imem_win = 1'b0;
    dmem_win = 1'b0;
    if (!rst_i) begin
      if (dmem_req_i && !(imem_req_i && (starve_q == LIMIT_C))) begin
        dmem_win = 1'b1;
      end else if (imem_req_i) begin
        imem_win = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = IDLE;
    store_d  = dmem_win && dmem_we_i;
    starve_d = starve_q;
    if (imem_win) begin
      state_d = IMEM_PEND;
    end else if (dmem_win) begin
      state_d = DMEM_PEND;
    end
    if (!imem_req_i || imem_win) begin
      starve_d = '0;
    end else if (dmem_win) begin
      starve_d = sat_inc(starve_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
      store_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      store_q  <= store_d;
    end
  end

  assign imem_gnt_o  = imem_win;
  assign dmem_gnt_o  = dmem_win;
  assign mem_en_o    = imem_win | dmem_win;
  assign mem_addr_o  = imem_win ? imem_addr_i : dmem_addr_i;
  assign mem_wdata_o = dmem_wdata_i;
  assign mem_we_o    = (dmem_win && dmem_we_i) ? dmem_be_i : 4'b0000;

  // The async reset clears state_q immediately, so the response side needs no extra gating.
  assign imem_rvalid_o = (state_q == IMEM_PEND);
  assign imem_rdata_o  = imem_rvalid_o ? mem_rdata_i : 32'h0;
  assign dmem_rvalid_o = (state_q == DMEM_PEND);
  assign dmem_rdata_o  = (dmem_rvalid_o && !store_q) ? mem_rdata_i : 32'h0;

endmodule
